// File: rtl/ats21_pkg.sv
// Shared types for the ATS21 client port: opcodes, response codes and FSM states.
package ats21_pkg;

  localparam int unsigned NUM_ALARMS_DEFAULT = 24;

  typedef enum logic [2:0] {
    OpNop    = 3'b000,
    OpSetClk = 3'b001,
    OpEnClk  = 3'b010,
    OpMode   = 3'b011,
    OpSetAlm = 3'b101,
    OpSetTmr = 3'b110,
    OpEnAlm  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    RspOk   = 2'b00,
    RspNack = 2'b01,
    RspSkip = 2'b11
  } rsp_code_e;

  typedef enum logic [2:0] {
    StIdle,
    StHi,
    StLo,
    StWait,
    StGap,
    StResp
  } client_state_e;

endpackage

// File: rtl/ats21_client_port_if.sv
// Host command/response and ATS21 pin bundle; slave is the client port, master drives it.
interface ats21_client_port_if #(
  parameter int unsigned NUM_ALARMS = 24
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [31:0]           cmd_instr;
  logic                  rsp_valid;
  logic [1:0]            rsp_code;
  logic [2:0]            rsp_retries;
  logic                  req;
  logic [15:0]           ctrl;
  logic [1:0]            stat;
  logic [NUM_ALARMS-1:0] alarm_data;
  logic [NUM_ALARMS-1:0] alarm_clr;
  logic [NUM_ALARMS-1:0] alarm_pend;
  logic                  irq;

  modport master (
    output cmd_valid, cmd_instr, stat, alarm_data, alarm_clr,
    input  cmd_ready, rsp_valid, rsp_code, rsp_retries, req, ctrl, alarm_pend, irq
  );

  modport slave (
    input  cmd_valid, cmd_instr, stat, alarm_data, alarm_clr,
    output cmd_ready, rsp_valid, rsp_code, rsp_retries, req, ctrl, alarm_pend, irq
  );
endinterface

// File: rtl/ats21_alarm_monitor.sv
// Captures rising edges of ATS21 alarm flags into sticky W1C pending bits and a registered irq.
module ats21_alarm_monitor #(
  parameter int unsigned NUM_ALARMS = 24
) (
  input  logic                  clk_1x,
  input  logic                  reset,
  input  logic [NUM_ALARMS-1:0] alarm_data,
  input  logic [NUM_ALARMS-1:0] alarm_clr,
  output logic [NUM_ALARMS-1:0] alarm_pend,
  output logic                  irq
);
  logic [NUM_ALARMS-1:0] prev_q;
  logic [NUM_ALARMS-1:0] pend_q, pend_d;
  logic                  irq_q;

  // A new rise overrides a clear on the same bit so no event is lost.
  always_comb begin
    pend_d = (pend_q & ~alarm_clr) | (alarm_data & ~prev_q);
  end

  always_ff @(posedge clk_1x or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= alarm_data;
      pend_q <= pend_d;
      irq_q  <= |pend_q;
    end
  end

  assign alarm_pend = pend_q;
  assign irq        = irq_q;
endmodule

// File: rtl/ats21_client_port.sv
// ATS21 client initiator: sends a 32-bit instruction as two 16-bit halves, retries on Nack.
module ats21_client_port
  import ats21_pkg::*;
#(
  parameter int unsigned CLIENT_SEL = 0,
  parameter int unsigned RESP_DLY   = 1,
  parameter int unsigned MAX_RETRY  = 2,
  parameter int unsigned NUM_ALARMS = NUM_ALARMS_DEFAULT
) (
  input logic              clk_1x,
  input logic              reset,
  ats21_client_port_if.slave bus
);
  localparam logic [3:0] RespDly  = 4'(RESP_DLY);
  localparam logic [2:0] MaxRetry = 3'(MAX_RETRY);

  client_state_e state_q, state_d;
  logic [31:0]   instr_q, instr_d;
  logic [3:0]    dly_q, dly_d;
  logic [2:0]    retry_q, retry_d;
  logic          req_q, req_d;
  logic [15:0]   ctrl_q, ctrl_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [1:0]    rsp_code_q, rsp_code_d;
  logic [2:0]    rsp_retries_q, rsp_retries_d;
  logic          stat_bit;

  assign stat_bit      = (CLIENT_SEL == 0) ? bus.stat[0] : bus.stat[1];
  assign bus.cmd_ready = (state_q == StIdle) && !reset;

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    dly_d         = dly_q;
    retry_d       = retry_q;
    rsp_code_d    = rsp_code_q;
    rsp_retries_d = rsp_retries_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid && bus.cmd_ready) begin
          instr_d = bus.cmd_instr;
          if (opcode_e'(bus.cmd_instr[31:29]) == OpNop) begin
            state_d       = StResp;
            rsp_code_d    = RspSkip;
            rsp_retries_d = 3'd0;
          end else begin
            state_d = StHi;
          end
        end
      end
      StHi: state_d = StLo;
      StLo: begin
        state_d = StWait;
        dly_d   = RespDly;
      end
      StWait: begin
        if (dly_q <= 4'd1) begin
          rsp_retries_d = retry_q;
          if (stat_bit) begin
            state_d    = StResp;
            rsp_code_d = RspOk;
          end else if (retry_q < MaxRetry) begin
            retry_d = retry_q + 3'd1;
            state_d = StGap;
          end else begin
            state_d    = StResp;
            rsp_code_d = RspNack;
          end
        end else begin
          dly_d = dly_q - 4'd1;
        end
      end
      StGap: state_d = StHi;
      StResp: begin
        retry_d = 3'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with it.
    req_d       = (state_d == StHi) || (state_d == StLo);
    rsp_valid_d = (state_d == StResp);
    ctrl_d      = 16'h0000;
    if (state_d == StHi) ctrl_d = instr_d[31:16];
    if (state_d == StLo) ctrl_d = instr_d[15:0];
  end

  always_ff @(posedge clk_1x or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      instr_q       <= '0;
      dly_q         <= '0;
      retry_q       <= '0;
      req_q         <= 1'b0;
      ctrl_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_code_q    <= RspOk;
      rsp_retries_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      dly_q         <= dly_d;
      retry_q       <= retry_d;
      req_q         <= req_d;
      ctrl_q        <= ctrl_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_code_q    <= rsp_code_d;
      rsp_retries_q <= rsp_retries_d;
    end
  end

  assign bus.req         = req_q;
  assign bus.ctrl        = ctrl_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_code    = rsp_code_q;
  assign bus.rsp_retries = rsp_retries_q;

  ats21_alarm_monitor #(
    .NUM_ALARMS (NUM_ALARMS)
  ) u_alarm_monitor (
    .clk_1x     (clk_1x),
    .reset      (reset),
    .alarm_data (bus.alarm_data),
    .alarm_clr  (bus.alarm_clr),
    .alarm_pend (bus.alarm_pend),
    .irq        (bus.irq)
  );
endmodule

// File: tb/tb_ats21_client_port.sv
// Directed bench for ats21_client_port: command serialisation, retries, alarms, mid-command reset.
module tb_ats21_client_port;
  logic clk_1x;
  logic reset;
  int   checks;
  int   errors;

  ats21_client_port_if #(.NUM_ALARMS(24)) bus ();

  ats21_client_port #(
    .CLIENT_SEL (0),
    .RESP_DLY   (1),
    .MAX_RETRY  (2),
    .NUM_ALARMS (24)
  ) dut (
    .clk_1x (clk_1x),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_1x = ~clk_1x;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_1x);
    #1;
  endtask

  // ack_from: attempt index from which stat[0] reads Ack (large = never).
  task automatic run_cmd(input logic [31:0] instr, input int ack_from, input logic [1:0] exp_code,
                         input logic [2:0] exp_retries, input int exp_lat);
    int   k;
    int   a;
    int   p;
    bit   done;
    logic exp_req;
    logic [15:0] exp_ctrl;
    k    = 0;
    done = 1'b0;
    check_eq("ready_before", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_instr = instr;
    bus.stat      = (ack_from == 0) ? 2'b01 : 2'b00;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_instr = 32'h0;
    while (!done && k < 40) begin
      k++;
      if (bus.rsp_valid) begin
        check_eq("rsp_latency", 32'(k), 32'(exp_lat));
        check_eq("rsp_code", 32'(bus.rsp_code), 32'(exp_code));
        check_eq("rsp_retries", 32'(bus.rsp_retries), 32'(exp_retries));
        check_eq("rsp_req_low", 32'(bus.req), 32'd0);
        done = 1'b1;
      end else begin
        a        = (k - 1) / 4;
        p        = (k - 1) % 4;
        exp_req  = (instr[31:29] != 3'b000) && (p < 2);
        exp_ctrl = !exp_req ? 16'h0 : (p == 0) ? instr[31:16] : instr[15:0];
        check_eq("req", 32'(bus.req), 32'(exp_req));
        check_eq("ctrl", 32'(bus.ctrl), 32'(exp_ctrl));
        bus.stat = (a >= ack_from) ? 2'b01 : 2'b00;
        step();
      end
    end
    if (!done) check_eq("rsp_timeout", 32'd0, 32'd1);
    step();
    check_eq("rsp_single_pulse", 32'(bus.rsp_valid), 32'd0);
    check_eq("ready_after", 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    clk_1x        = 1'b0;
    reset         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_instr = 32'h0;
    bus.stat      = 2'b00;
    bus.alarm_data = 24'h0;
    bus.alarm_clr  = 24'h0;
    #2 reset = 1'b1;
    step();
    step();
    check_eq("rst_req", 32'(bus.req), 32'd0);
    check_eq("rst_ctrl", 32'(bus.ctrl), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_code", 32'(bus.rsp_code), 32'd0);
    check_eq("rst_rsp_retries", 32'(bus.rsp_retries), 32'd0);
    check_eq("rst_pend", 32'(bus.alarm_pend), 32'd0);
    check_eq("rst_irq", 32'(bus.irq), 32'd0);
    check_eq("rst_ready", 32'(bus.cmd_ready), 32'd0);
    reset = 1'b0;
    step();

    run_cmd(32'h2A40_0010, 0, 2'b00, 3'd0, 4);
    run_cmd(32'h0000_0000, 0, 2'b11, 3'd0, 1);
    run_cmd(32'hA123_4567, 99, 2'b01, 3'd2, 12);
    run_cmd(32'hC0FF_EE01, 1, 2'b00, 3'd1, 8);

    // Alarm capture, set-over-clear, held flag not recaptured.
    bus.alarm_data = 24'h000008;
    step();
    check_eq("alm_pend_rise", 32'(bus.alarm_pend), 32'h8);
    check_eq("alm_irq_lag", 32'(bus.irq), 32'd0);
    step();
    check_eq("alm_pend_held", 32'(bus.alarm_pend), 32'h8);
    check_eq("alm_irq", 32'(bus.irq), 32'd1);
    bus.alarm_data = 24'h0;
    step();
    check_eq("alm_pend_sticky", 32'(bus.alarm_pend), 32'h8);
    bus.alarm_data = 24'h000008;
    bus.alarm_clr  = 24'h000008;
    step();
    check_eq("alm_set_wins", 32'(bus.alarm_pend), 32'h8);
    step();
    check_eq("alm_clr", 32'(bus.alarm_pend), 32'h0);
    bus.alarm_clr = 24'h0;
    step();
    check_eq("alm_no_recapture", 32'(bus.alarm_pend), 32'h0);
    check_eq("alm_irq_drop", 32'(bus.irq), 32'd0);
    bus.alarm_data = 24'h0;

    // Reset asserted while the low half is on the bus.
    bus.alarm_data = 24'h000080;
    step();
    bus.alarm_data = 24'h0;
    check_eq("alm_pend_b7", 32'(bus.alarm_pend), 32'h80);
    bus.cmd_valid = 1'b1;
    bus.cmd_instr = 32'h6ABC_1234;
    bus.stat      = 2'b01;
    step();
    bus.cmd_valid = 1'b0;
    check_eq("mid_hi_ctrl", 32'(bus.ctrl), 32'h6ABC);
    step();
    check_eq("mid_lo_ctrl", 32'(bus.ctrl), 32'h1234);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_req", 32'(bus.req), 32'd0);
    check_eq("mid_rst_ctrl", 32'(bus.ctrl), 32'd0);
    check_eq("mid_rst_pend", 32'(bus.alarm_pend), 32'd0);
    step();
    reset = 1'b0;
    #1;
    check_eq("mid_ready", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check_eq("mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
      check_eq("mid_no_req", 32'(bus.req), 32'd0);
      step();
    end
    run_cmd(32'h3000_00FF, 0, 2'b00, 3'd0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
